multicycle_ctrl: RTL and testbench

Multi-cycle control unit that drives the datapath top level's control inputs and consumes its `eq` and `jalrOutput` results. It fetches one RV32I instruction at a time from a combinational instruction memory and decodes it. It sequences FETCH/DECODE/EXEC/MEM/WB and owns the program counter, including branch and jump resolution.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Datapath-side bundle of the multicycle control unit.
// master = control unit, slave = datapath.
interface multicycle_ctrl_if #(
    parameter int Data_Width            = 32,
    parameter int Address_Width_RegFile = 5
);
    logic                             eq;
    logic [Data_Width-1:0]            jalrOutput;
    logic [Address_Width_RegFile-1:0] rs1;
    logic [Address_Width_RegFile-1:0] rs2;
    logic [Address_Width_RegFile-1:0] rd;
    logic                             regFileWen;
    logic                             ALUSrc;
    logic [Data_Width-1:0]            ImmOp;
    logic [3:0]                       ALU_ctrl;
    logic                             MemWrite;
    logic [1:0]                       dataType;
    logic                             SrcSel;
    logic                             JumpSel;
    logic [Data_Width-1:0]            newPC;

    modport master (
        input  eq, jalrOutput,
        output rs1, rs2, rd, regFileWen, ALUSrc, ImmOp, ALU_ctrl,
        output MemWrite, dataType, SrcSel, JumpSel, newPC
    );

    modport slave (
        output eq, jalrOutput,
        input  rs1, rs2, rd, regFileWen, ALUSrc, ImmOp, ALU_ctrl,
        input  MemWrite, dataType, SrcSel, JumpSel, newPC
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I subset multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB plus PC.
// Define MC_CTRL_PERF_EN to build the retired-instruction counter.
module multicycle_ctrl #(
    parameter int          Data_Width            = 32,
    parameter int          Address_Width_RegFile = 5,
    parameter logic [31:0] RESET_PC              = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        illegal,
    output logic [31:0] instret,
    multicycle_ctrl_if.master dp
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JL = 7'b1101111;
    localparam logic [6:0] OP_JR = 7'b1100111;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2;
    localparam logic [3:0] A_OR  = 4'd3, A_XOR = 4'd4, A_SLL = 4'd5;
    localparam logic [3:0] A_SRL = 4'd6, A_SLT = 4'd7, A_PAS = 4'd8;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t                state, state_n;
    logic [31:0]           ir;
    logic [Data_Width-1:0] pc, pc_n;
    logic                  retire;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [3:0]  alu;
    logic [1:0]  dt;
    logic        asrc, ssel, jsel, bad;
    logic        is_lui, is_ld, is_st, is_br, is_jal, is_jalr;

    assign opc   = ir[6:0];
    assign f3    = ir[14:12];
    assign f7    = ir[31:25];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        alu = A_ADD; imm = '0; dt = 2'b00;
        asrc = 1'b0; ssel = 1'b0; jsel = 1'b0; bad = 1'b1;
        is_lui = 1'b0; is_ld = 1'b0; is_st = 1'b0;
        is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        unique case (1'b1)
            (opc == OP_R): begin
                bad = (f7 != 7'b0) && !(f7 == 7'b0100000 && f3 == 3'b000);
                unique case (f3)
                    3'b000:  alu = f7[5] ? A_SUB : A_ADD;
                    3'b001:  alu = A_SLL;
                    3'b010:  alu = A_SLT;
                    3'b100:  alu = A_XOR;
                    3'b101:  alu = A_SRL;
                    3'b110:  alu = A_OR;
                    3'b111:  alu = A_AND;
                    default: bad = 1'b1;
                endcase
            end
            (opc == OP_I): begin
                asrc = 1'b1; imm = imm_i;
                // Shift immediates only allow funct7 = 0 (no SRAI).
                bad  = (f3[1:0] == 2'b01) && (f7 != 7'b0);
                unique case (f3)
                    3'b000:  alu = A_ADD;
                    3'b001:  alu = A_SLL;
                    3'b010:  alu = A_SLT;
                    3'b100:  alu = A_XOR;
                    3'b101:  alu = A_SRL;
                    3'b110:  alu = A_OR;
                    3'b111:  alu = A_AND;
                    default: bad = 1'b1;
                endcase
            end
            (opc == OP_LU): begin
                bad = 1'b0; is_lui = 1'b1;
                alu = A_PAS; asrc = 1'b1; imm = imm_u;
            end
            (opc == OP_LD): begin
                is_ld = 1'b1; asrc = 1'b1; ssel = 1'b1; imm = imm_i;
                unique case (f3)
                    3'b010:  begin bad = 1'b0; dt = 2'b00; end
                    3'b100:  begin bad = 1'b0; dt = 2'b01; end
                    3'b101:  begin bad = 1'b0; dt = 2'b10; end
                    default: bad = 1'b1;
                endcase
            end
            (opc == OP_ST): begin
                is_st = 1'b1; asrc = 1'b1; imm = imm_s;
                unique case (f3)
                    3'b000:  begin bad = 1'b0; dt = 2'b01; end
                    3'b001:  begin bad = 1'b0; dt = 2'b10; end
                    3'b010:  begin bad = 1'b0; dt = 2'b00; end
                    default: bad = 1'b1;
                endcase
            end
            (opc == OP_BR): begin
                is_br = 1'b1; alu = A_SUB; imm = imm_b;
                bad   = (f3[2:1] != 2'b00);
            end
            (opc == OP_JL): begin
                bad = 1'b0; is_jal = 1'b1; jsel = 1'b1; imm = imm_j;
            end
            (opc == OP_JR): begin
                is_jalr = 1'b1; jsel = 1'b1; asrc = 1'b1; imm = imm_i;
                bad     = (f3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        retire  = 1'b0;
        if (!stall) begin
            unique case (state)
                FETCH:  state_n = DECODE;
                DECODE: state_n = bad ? TRAP : EXEC;
                EXEC: begin
                    if (is_br) begin
                        state_n = FETCH; retire = 1'b1;
                    end else if (is_ld || is_st) begin
                        state_n = MEM;
                    end else begin
                        state_n = WB;
                    end
                end
                MEM: begin
                    state_n = is_st ? FETCH : WB;
                    retire  = is_st;
                end
                WB: begin
                    state_n = FETCH; retire = 1'b1;
                end
                default: state_n = TRAP;
            endcase
        end
    end

    always_comb begin
        pc_n = pc + Data_Width'(4);
        // BNE is funct3 001, so ir[12] inverts the equality sense.
        if (is_jal || (is_br && (dp.eq ^ ir[12])))
            pc_n = pc + Data_Width'(imm);
        if (is_jalr)
            pc_n = dp.jalrOutput & ~Data_Width'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= Data_Width'(RESET_PC);
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && !stall) ir <= imem_rdata;
            if (retire) pc <= pc_n;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (retire) cnt <= cnt + 32'd1;
    end
    assign instret = cnt;
`else
    assign instret = '0;
`endif

    assign imem_addr     = 32'(pc);
    assign illegal       = (state == TRAP);
    assign dp.newPC      = pc + Data_Width'(4);
    assign dp.rs1        = is_lui ? '0 : Address_Width_RegFile'(ir[19:15]);
    assign dp.rs2        = Address_Width_RegFile'(ir[24:20]);
    assign dp.rd         = Address_Width_RegFile'(ir[11:7]);
    assign dp.ImmOp      = Data_Width'(imm);
    assign dp.ALU_ctrl   = alu;
    assign dp.ALUSrc     = asrc;
    assign dp.dataType   = dt;
    assign dp.SrcSel     = ssel;
    assign dp.JumpSel    = jsel;
    assign dp.regFileWen = (state == WB) && !stall && (ir[11:7] != 5'd0);
    assign dp.MemWrite   = (state == MEM) && is_st && !stall;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a table-driven ISA model.
// Instruction memory is modelled as the word presented for the current fetch.
module tb_multicycle_ctrl;
    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3;
    localparam int C_JAL = 4, C_JALR = 5, C_LUI = 6;
    // immediate kinds: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J

    typedef struct {
        logic [31:0] match;
        logic [31:0] mask;
        int          cls;
        logic [3:0]  alu;
        int          it;
        bit          asrc;
        logic [1:0]  dt;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        illegal;
    logic [31:0] instret;

    multicycle_ctrl_if dp ();

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .illegal    (illegal),
        .instret    (instret),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    row_t        tbl[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_ir = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] m, input logic [31:0] k,
                       input int c, input logic [3:0] a, input int it,
                       input bit s, input logic [1:0] d);
        row_t r;
        r.match = m; r.mask = k; r.cls = c; r.alu = a;
        r.it = it; r.asrc = s; r.dt = d;
        tbl.push_back(r);
    endtask

    function automatic int lookup(input logic [31:0] i);
        foreach (tbl[n])
            if ((i & tbl[n].mask) == tbl[n].match) return n;
        return -1;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i, input int it);
        case (it)
            1: return 32'($signed(i[31:20]));
            2: return 32'($signed({i[31:25], i[11:7]}));
            3: return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            4: return {i[31:12], 12'h000};
            5: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: return 32'h0;
        endcase
    endfunction

    function automatic int cpi_of(input int c);
        case (c)
            C_LD: return 5;
            C_BR: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit writes(input int c);
        return c == C_ALU || c == C_LD || c == C_JAL || c == C_JALR || c == C_LUI;
    endfunction

    task automatic check_fields(input logic [31:0] ins, input row_t e);
        chk("rs1", 32'(dp.rs1), e.cls == C_LUI ? 32'h0 : 32'(ins[19:15]));
        if (writes(e.cls)) chk("rd", 32'(dp.rd), 32'(ins[11:7]));
        if (e.it == 0 || e.it == 2 || e.it == 3)
            chk("rs2", 32'(dp.rs2), 32'(ins[24:20]));
        if (e.it != 0) chk("imm", dp.ImmOp, imm_of(ins, e.it));
        if (e.cls != C_JAL) begin
            chk("alu", 32'(dp.ALU_ctrl), 32'(e.alu));
            chk("asrc", 32'(dp.ALUSrc), 32'(e.asrc));
        end
        if (e.cls == C_LD || e.cls == C_ST)
            chk("dtype", 32'(dp.dataType), 32'(e.dt));
        chk("srcsel", 32'(dp.SrcSel), 32'(e.cls == C_LD));
        chk("jumpsel", 32'(dp.JumpSel), 32'(e.cls == C_JAL || e.cls == C_JALR));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_wen", 32'(dp.regFileWen), 32'h0);
        chk("rst_mwr", 32'(dp.MemWrite), 32'h0);
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_ill", 32'(illegal), 32'h0);
        chk("rst_cnt", instret, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = 32'h0;
        exp_ir = 32'h0;
    endtask

    // smode: 0 no stall, 1 random stall, 2 stall three cycles in MEM
    task automatic run(input logic [31:0] ins, input bit eqv,
                       input logic [31:0] jo, input int smode);
        int   r, cpi, k, guard, held;
        bit   st, last;
        row_t e;
        logic [31:0] imm;
        r = lookup(ins);
        imem_rdata = ins;
        dp.eq = eqv;
        dp.jalrOutput = jo;
        e = '{default: '0};
        if (r >= 0) e = tbl[r];
        cpi = (r >= 0) ? cpi_of(e.cls) : 2;
        k = 0; guard = 0; held = 0;
        while (k < cpi && guard < 100) begin
            if (smode == 1) st = ($urandom_range(0, 3) == 0);
            else st = (smode == 2) && (k == 3) && (held < 3);
            if (st) held++;
            stall = st;
            @(negedge clk);
            last = !st && (k + 1 == cpi);
            chk("pc_hold", imem_addr, exp_pc);
            chk("wen", 32'(dp.regFileWen),
                32'(last && r >= 0 && writes(e.cls) && ins[11:7] != 5'd0));
            chk("mwr", 32'(dp.MemWrite), 32'(last && r >= 0 && e.cls == C_ST));
            if (last && r >= 0) check_fields(ins, e);
            @(posedge clk);
            #1;
            if (!st) k++;
            guard++;
        end
        stall = 1'b0;
        if (k != cpi) chk("cycle_budget", 32'(k), 32'(cpi));
        if (r < 0) begin
            chk("trap", 32'(illegal), 32'h1);
            repeat (20) begin
                @(negedge clk);
                chk("trap_wen", 32'(dp.regFileWen), 32'h0);
                chk("trap_mwr", 32'(dp.MemWrite), 32'h0);
                chk("trap_pc", imem_addr, exp_pc);
                chk("trap_ill", 32'(illegal), 32'h1);
            end
            do_reset();
        end else begin
            imm = imm_of(ins, e.it);
            case (e.cls)
                C_BR:    exp_pc = (eqv ^ ins[12]) ? exp_pc + imm : exp_pc + 32'd4;
                C_JAL:   exp_pc = exp_pc + imm;
                C_JALR:  exp_pc = {jo[31:1], 1'b0};
                default: exp_pc = exp_pc + 32'd4;
            endcase
`ifdef MC_CTRL_PERF_EN
            exp_ir = exp_ir + 32'd1;
`endif
            chk("pc_next", imem_addr, exp_pc);
            chk("newpc", dp.newPC, exp_pc + 32'd4);
            chk("instret", instret, exp_ir);
            chk("no_trap", 32'(illegal), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] ins;
        int          r;
        add(32'h00000033, 32'hFE00707F, C_ALU, 4'd0, 0, 1'b0, 2'd0);
        add(32'h40000033, 32'hFE00707F, C_ALU, 4'd1, 0, 1'b0, 2'd0);
        add(32'h00001033, 32'hFE00707F, C_ALU, 4'd5, 0, 1'b0, 2'd0);
        add(32'h00002033, 32'hFE00707F, C_ALU, 4'd7, 0, 1'b0, 2'd0);
        add(32'h00004033, 32'hFE00707F, C_ALU, 4'd4, 0, 1'b0, 2'd0);
        add(32'h00005033, 32'hFE00707F, C_ALU, 4'd6, 0, 1'b0, 2'd0);
        add(32'h00006033, 32'hFE00707F, C_ALU, 4'd3, 0, 1'b0, 2'd0);
        add(32'h00007033, 32'hFE00707F, C_ALU, 4'd2, 0, 1'b0, 2'd0);
        add(32'h00000013, 32'h0000707F, C_ALU, 4'd0, 1, 1'b1, 2'd0);
        add(32'h00002013, 32'h0000707F, C_ALU, 4'd7, 1, 1'b1, 2'd0);
        add(32'h00004013, 32'h0000707F, C_ALU, 4'd4, 1, 1'b1, 2'd0);
        add(32'h00006013, 32'h0000707F, C_ALU, 4'd3, 1, 1'b1, 2'd0);
        add(32'h00007013, 32'h0000707F, C_ALU, 4'd2, 1, 1'b1, 2'd0);
        add(32'h00001013, 32'hFE00707F, C_ALU, 4'd5, 1, 1'b1, 2'd0);
        add(32'h00005013, 32'hFE00707F, C_ALU, 4'd6, 1, 1'b1, 2'd0);
        add(32'h00000037, 32'h0000007F, C_LUI, 4'd8, 4, 1'b1, 2'd0);
        add(32'h00002003, 32'h0000707F, C_LD,  4'd0, 1, 1'b1, 2'd0);
        add(32'h00004003, 32'h0000707F, C_LD,  4'd0, 1, 1'b1, 2'd1);
        add(32'h00005003, 32'h0000707F, C_LD,  4'd0, 1, 1'b1, 2'd2);
        add(32'h00002023, 32'h0000707F, C_ST,  4'd0, 2, 1'b1, 2'd0);
        add(32'h00000023, 32'h0000707F, C_ST,  4'd0, 2, 1'b1, 2'd1);
        add(32'h00001023, 32'h0000707F, C_ST,  4'd0, 2, 1'b1, 2'd2);
        add(32'h00000063, 32'h0000707F, C_BR,  4'd1, 3, 1'b0, 2'd0);
        add(32'h00001063, 32'h0000707F, C_BR,  4'd1, 3, 1'b0, 2'd0);
        add(32'h0000006F, 32'h0000007F, C_JAL, 4'd0, 5, 1'b0, 2'd0);
        add(32'h00000067, 32'h0000707F, C_JALR, 4'd0, 1, 1'b1, 2'd0);

        rst = 1'b0;
        stall = 1'b0;
        imem_rdata = 32'h0;
        dp.eq = 1'b0;
        dp.jalrOutput = 32'h0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("init_addr", imem_addr, 32'h0);
        chk("init_newpc", dp.newPC, 32'h4);
        chk("init_wen", 32'(dp.regFileWen), 32'h0);
        chk("init_mwr", 32'(dp.MemWrite), 32'h0);
        chk("init_ill", 32'(illegal), 32'h0);
        chk("init_cnt", instret, 32'h0);
        chk("init_rd", 32'(dp.rd), 32'h0);
        chk("init_imm", dp.ImmOp, 32'h0);
        chk("init_alu", 32'(dp.ALU_ctrl), 32'h0);
        rst = 1'b0;

        run(32'h00500093, 1'b0, 32'h0, 0);
        repeat (3) run(32'h00000013, 1'b0, 32'h0, 0);
        run(32'hFE000CE3, 1'b1, 32'h0, 0);
        repeat (2) run(32'h00000013, 1'b0, 32'h0, 0);
        run(32'hFE000CE3, 1'b0, 32'h0, 0);
        run(32'h00314283, 1'b0, 32'h0, 0);
        run(32'h00312023, 1'b0, 32'h0, 0);
        run(32'h000300E7, 1'b0, 32'h123, 0);
        run(32'h00312023, 1'b0, 32'h0, 2);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, tbl.size() - 1);
            ins = tbl[r].match | ($urandom() & ~tbl[r].mask);
            if ($urandom_range(0, 9) == 0)
                ins = ins ^ (32'h1 << $urandom_range(0, 31));
            run(ins, 1'($urandom()), $urandom(), 1);
        end

        // reset during MEM of a store must drop the write strobe at once
        imem_rdata = 32'h00312023;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_mwr", 32'(dp.MemWrite), 32'h1);
        do_reset();

        run(32'h0000007F, 1'b0, 32'h0, 0);
        run(32'h00500093, 1'b0, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
